// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch slice.
//   imem_status_t : response status codes from the instruction memory
//   fetch_entry_t : one buffered {pc, inst} pair handed to decode
//   fetch_state_t : fetch control states
//   INST_BYTES    : PC increment per fetched instruction
package fetch_pkg;

  typedef enum logic [1:0] {
    IMEM_IDLE  = 2'b00,
    IMEM_BUSY  = 2'b01,
    IMEM_VALID = 2'b10
  } imem_status_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_FULL
  } fetch_state_t;

  localparam int unsigned INST_BYTES = 4;

endpackage

// File: rtl/inst_fetch_unit_if.sv
// Instruction-memory request/response bus.
//   imem_addr          : request address (initiator -> memory)
//   imem_stall         : abort / hold memory idle (initiator -> memory)
//   imem_r_data        : read data, meaningful when status is VALID
//   imem_r_data_status : 00 IDLE, 01 BUSY, 10 VALID, 11 reserved
// master = fetch unit, slave = memory.
interface inst_fetch_unit_if;
  logic [31:0] imem_addr;
  logic        imem_stall;
  logic [31:0] imem_r_data;
  logic [1:0]  imem_r_data_status;

  modport master (
    output imem_addr,
    output imem_stall,
    input  imem_r_data,
    input  imem_r_data_status
  );

  modport slave (
    input  imem_addr,
    input  imem_stall,
    output imem_r_data,
    output imem_r_data_status
  );
endinterface

// File: rtl/fetch_queue.sv
// Power-of-two depth FIFO of fetch_entry_t.
//   push/push_data : enqueue (ignored when full)
//   pop            : dequeue head (ignored when empty)
//   flush          : empty the queue; overrides push and pop
//   head           : registered head entry
//   count/full/empty : occupancy
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  input  logic                     flush,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           push_fire;
  logic           pop_fire;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign push_fire = push && !full;
  assign pop_fire  = pop && !empty;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_fire) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop_fire) rd_ptr <= rd_ptr + AW'(1);
      if (push_fire && !pop_fire)      count <= count + CW'(1);
      else if (pop_fire && !push_fire) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: initiator of instruction-memory requests.
//   clk, rst        : clock, synchronous active-low reset
//   fetch_en        : fetching permitted
//   redirect_valid  : restart fetch at redirect_pc (word aligned), flush queue
//   imem            : memory bus (master side)
//   inst_valid/inst/inst_pc/inst_ready : queue head handshake to decode
module inst_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fetch_en,
  input  logic                      redirect_valid,
  input  logic [31:0]               redirect_pc,
  inst_fetch_unit_if.master         imem,
  output logic                      inst_valid,
  output logic [31:0]               inst,
  output logic [31:0]               inst_pc,
  input  logic                      inst_ready
);

  localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

  fetch_state_t   state, state_n;
  logic [31:0]    pc, pc_n;
  logic           push;
  logic           pop;
  logic           q_full;
  logic           q_empty;
  logic [CW-1:0]  q_count;
  fetch_entry_t   q_head;
  fetch_entry_t   push_entry;

  assign push_entry = '{pc: pc, inst: imem.imem_r_data};
  assign pop        = inst_valid && inst_ready;

  fetch_queue #(.DEPTH(QUEUE_DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (q_head),
    .count     (q_count),
    .full      (q_full),
    .empty     (q_empty)
  );

  assign inst_valid      = !q_empty;
  assign inst            = q_head.inst;
  assign inst_pc         = q_head.pc;
  assign imem.imem_addr  = pc;
  assign imem.imem_stall = !rst || redirect_valid || (state != S_FETCH);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_n;
      pc    <= pc_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    push    = 1'b0;
    if (redirect_valid) begin
      pc_n    = redirect_pc & ~32'h3;
      state_n = fetch_en ? S_FETCH : S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (fetch_en && !q_full) state_n = S_FETCH;
        end
        S_FETCH: begin
          // Once a request is outstanding it runs to completion; fetch_en
          // only matters after the response has been pushed.
          if (imem.imem_r_data_status == IMEM_VALID) begin
            push = 1'b1;
            pc_n = pc + 32'(INST_BYTES);
            if (!pop && q_count == CW'(QUEUE_DEPTH - 1)) state_n = S_FULL;
            else if (!fetch_en)                          state_n = S_IDLE;
          end
        end
        S_FULL: begin
          if (!q_full) state_n = fetch_en ? S_FETCH : S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_unit.sv
module tb_inst_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  int checks = 0;
  int errors = 0;

  inst_fetch_unit_if imem ();

  inst_fetch_unit #(.RESET_PC(32'hBFC0_0000), .QUEUE_DEPTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem.master),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready)
  );

  always #5 clk = ~clk;

  // Memory model, latency 2: IDLE 1 cycle, BUSY 3 cycles, VALID 1 cycle.
  logic [1:0]  mst  = 2'b00;
  int          mcnt = 0;
  logic [31:0] mdat = '0;
  assign imem.imem_r_data_status = mst;
  assign imem.imem_r_data        = mdat;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hBFC0_0000) return 32'h2408_0001;
    if (a == 32'hBFC0_0004) return 32'h2409_0002;
    return a ^ 32'hA5A5_A5A5;
  endfunction

  always @(posedge clk) begin
    if (imem.imem_stall) begin
      mst  <= 2'b00;
      mcnt <= 0;
    end else begin
      case (mst)
        2'b00: begin mst <= 2'b01; mcnt <= 0; end
        2'b01: begin
          if (mcnt == 2) begin
            mst  <= 2'b10;
            mdat <= mem_word(imem.imem_addr);
          end else mcnt <= mcnt + 1;
        end
        default: mst <= 2'b00;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Counts edges until inst_valid rises; a timeout shows up as a wrong count.
  task automatic wait_valid(input string tag, input int exp_n);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!inst_valid && n < 40);
    chk(tag, n, exp_n);
  endtask

  initial begin
    rst = 1'b0; fetch_en = 1'b0; redirect_valid = 1'b0;
    redirect_pc = '0; inst_ready = 1'b1;
    tick(); tick();
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_addr", imem.imem_addr, 32'hBFC0_0000);
    chk("rst_stall", imem.imem_stall, 1);

    // Streaming with decode always ready
    rst = 1'b1; fetch_en = 1'b1;
    tick();
    chk("a_stall", imem.imem_stall, 0);
    wait_valid("a_lat1", 5);
    chk("a_pc1", inst_pc, 32'hBFC0_0000);
    chk("a_inst1", inst, 32'h2408_0001);
    wait_valid("a_lat2", 5);
    chk("a_pc2", inst_pc, 32'hBFC0_0004);
    chk("a_inst2", inst, 32'h2409_0002);

    // Backpressure from a fresh reset
    rst = 1'b0; inst_ready = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    wait_valid("b_lat1", 5);
    repeat (25) tick();
    chk("b_head_pc", inst_pc, 32'hBFC0_0000);
    chk("b_head_inst", inst, 32'h2408_0001);
    chk("b_stall", imem.imem_stall, 1);
    chk("b_addr", imem.imem_addr, 32'hBFC0_0008);
    inst_ready = 1'b1;
    tick();
    chk("b_valid2", inst_valid, 1);
    chk("b_pc2", inst_pc, 32'hBFC0_0004);
    chk("b_inst2", inst, 32'h2409_0002);
    chk("b_stall2", imem.imem_stall, 1);
    tick();
    chk("b_empty", inst_valid, 0);
    chk("b_refetch", imem.imem_stall, 0);
    wait_valid("b_lat3", 5);
    chk("b_pc3", inst_pc, 32'hBFC0_0008);
    chk("b_inst3", inst, 32'h1A65_A5AD);

    // Redirect while memory is BUSY, queue holding one entry
    inst_ready = 1'b0;
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h8000_0102;
    #1;
    chk("c_stall", imem.imem_stall, 1);
    tick();
    redirect_valid = 1'b0;
    chk("c_flush", inst_valid, 0);
    chk("c_addr", imem.imem_addr, 32'h8000_0100);
    inst_ready = 1'b1;
    wait_valid("c_lat", 5);
    chk("c_pc", inst_pc, 32'h8000_0100);
    chk("c_inst", inst, 32'h25A5_A4A5);

    // Redirect coinciding with VALID, queue non-empty; target exercises wrap
    inst_ready = 1'b0;
    repeat (4) tick();
    chk("d_status", imem.imem_r_data_status, 2'b10);
    chk("d_held", inst_valid, 1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    tick();
    redirect_valid = 1'b0;
    chk("d_flush", inst_valid, 0);
    chk("d_addr", imem.imem_addr, 32'hFFFF_FFFC);
    wait_valid("d_lat", 5);
    chk("d_pc", inst_pc, 32'hFFFF_FFFC);
    chk("d_inst", inst, 32'h5A5A_5A59);
    chk("d_wrap", imem.imem_addr, 32'h0000_0000);

    // Reset mid-BUSY with one entry queued
    tick();
    rst = 1'b0;
    #1;
    chk("e_stall", imem.imem_stall, 1);
    tick();
    chk("e_valid", inst_valid, 0);
    chk("e_addr", imem.imem_addr, 32'hBFC0_0000);
    chk("e_pc", inst_pc, 0);
    chk("e_stall2", imem.imem_stall, 1);

    // Fetch disabled stays idle
    rst = 1'b1; fetch_en = 1'b0;
    repeat (3) tick();
    chk("f_stall", imem.imem_stall, 1);
    chk("f_valid", inst_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Initiator side of the instruction-memory request/response protocol. Holds the fetch PC and drives the memory address and stall lines.
- Captures each returned instruction word when memory reports data valid, and buffers {pc, inst} pairs in a small queue for the decode stage.
- Handles decode backpressure and branch/jump redirects. Sits between the PC-redirect logic and the instruction memory.

Parameters:
- RESET_PC, 32'hBFC0_0000, fetch address loaded at reset.
- QUEUE_DEPTH, 2, number of fetched-instruction entries buffered (power of 2, >=2).

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous, active-low reset (0 = reset).
- fetch_en  in  1  1 = fetching permitted; 0 = hold idle.
- redirect_valid  in  1  1-cycle pulse: discard in-flight work and restart fetch at redirect_pc.
- redirect_pc  in  32  new fetch address; bits [1:0] are ignored (forced to 0).
- imem_addr  out  32  address to memory; registered; stable for the whole request.
- imem_stall  out  1  combinational; 1 forces memory back to status IDLE and aborts the request.
- imem_r_data  in  32  memory read data; meaningful only when status = VALID.
- imem_r_data_status  in  2  00 IDLE, 01 BUSY, 10 VALID (one cycle), 11 reserved (treated as BUSY).
- inst_valid  out  1  queue head valid.
- inst  out  32  queue head instruction word.
- inst_pc  out  32  queue head PC.
- inst_ready  in  1  decode accepts the head when inst_valid && inst_ready.

Behaviour:
- Reset (rst=0 at posedge):
  - pc=RESET_PC; queue empty; FSM=S_IDLE.
  - Outputs: inst_valid=0, inst=0, inst_pc=0, imem_addr=RESET_PC.
  - imem_stall=1 combinationally whenever rst=0.
- imem_addr = pc register. It changes only on a capture or a redirect edge.
- FSM S_IDLE:
  - imem_stall=1.
  - Go to S_FETCH when fetch_en=1 and the queue is not full.
- FSM S_FETCH:
  - imem_stall=0.
  - On status=VALID: push {pc, imem_r_data}; pc<=pc+4 (32-bit wrap, 32'hFFFF_FFFC -> 0).
  - If the push makes the queue full, go to S_FULL. Else if fetch_en=0, go to S_IDLE.
  - fetch_en dropping mid-request does not abort the request: it completes, is pushed, then the FSM goes to S_IDLE.
- FSM S_FULL:
  - imem_stall=1.
  - Go to S_FETCH (or S_IDLE if fetch_en=0) on the first edge where count < QUEUE_DEPTH.
- Queue:
  - FIFO with push and pop in the same cycle allowed; count is unchanged in that case.
  - Pop occurs on inst_valid && inst_ready. Pop when empty is a no-op.
  - A push never occurs when full: the memory is held stalled, so no VALID can arrive.
  - inst_valid = (count != 0). The head fields come from registers; no combinational path from memory to inst*.
- Redirect (highest priority, any state):
  - Same cycle: imem_stall=1 combinationally.
  - At the edge: pc<=redirect_pc & ~3; queue flushed (count=0); any simultaneous VALID response or pop is discarded.
  - FSM goes to S_FETCH if fetch_en=1, else S_IDLE.
  - Cycle after: inst_valid=0.
- Throughput with memory latency_cycles=2:
  - The memory spends 1 cycle IDLE, 3 cycles BUSY and 1 cycle VALID, so 5 cycles per instruction.
  - The first inst_valid=1 follows the 5th posedge after the first edge with rst=1 (fetch_en=1, no stalls).
- Status 11 or a BUSY of unbounded length: keep waiting. There is no timeout.
- Reset mid-request: memory is aborted via imem_stall; the queue and PC are reinitialised.

Decomposition:
- fetch_pkg holds:
  - typedef enum logic [1:0] imem_status_t {IMEM_IDLE=2'b00, IMEM_BUSY=2'b01, IMEM_VALID=2'b10}.
  - typedef struct packed fetch_entry_t {logic [31:0] pc; logic [31:0] inst}.
  - typedef enum fetch_state_t {S_IDLE, S_FETCH, S_FULL}.
  - localparam INST_BYTES=4.
- Sub-module fetch_queue (parameterised depth FIFO of fetch_entry_t):
  - inputs push, pop, flush;
  - outputs head, count, full, empty.
- Top: FSM, PC register, stall logic.

Test Plan:
- Reset release, fetch_en=1, inst_ready=1, memory latency 2, mem[BFC00000]=0x2408_0001, mem[BFC00004]=0x2409_0002:
  - inst_valid pulses every 5 cycles;
  - first beat inst_pc=BFC00000, inst=24080001; second beat inst_pc=BFC00004, inst=24090002.
- inst_ready=0 for 30 cycles:
  - exactly 2 entries (BFC00000, BFC00004) are held;
  - imem_stall=1 and imem_addr=BFC00008 while full;
  - after inst_ready=1 the entries drain in order, then BFC00008 is fetched.
- redirect_valid with redirect_pc=0x8000_0102 while status=BUSY:
  - imem_stall=1 that cycle; next cycle imem_addr=80000100 and inst_valid=0;
  - next delivered inst_pc=80000100, no stale word.
- redirect_valid in the same cycle as status=VALID with a non-empty queue:
  - response dropped; queue empty next cycle;
  - fetch restarts at the redirect target.
- pc=FFFFFFFC fetch:
  - delivered inst_pc=FFFFFFFC; next imem_addr=00000000.
- rst=0 asserted mid-BUSY with 1 entry queued:
  - next cycle inst_valid=0, imem_addr=BFC00000, imem_stall=1 while rst=0.
